// File: rtl/weight_access_arbiter_if.sv
// Bundle of requester handshakes and weight-memory pins for weight_access_arbiter.
// The master modport is the requester/memory side; the slave modport is the arbiter.
interface weight_access_arbiter_if #(
    parameter int AW = 7
);
    logic          init_start;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          rd_gnt;
    logic          rd_done;
    logic          wr_gnt;
    logic          wr_done;
    logic          init_busy;
    logic          mem_In;
    logic [AW-1:0] mem_Address;
    logic          mem_WE;
    logic          mem_en;
    logic          err;

    modport master (
        output init_start, rd_req, rd_addr, wr_req, wr_addr,
        input  rd_gnt, rd_done, wr_gnt, wr_done, init_busy,
        input  mem_In, mem_Address, mem_WE, mem_en, err
    );

    modport slave (
        input  init_start, rd_req, rd_addr, wr_req, wr_addr,
        output rd_gnt, rd_done, wr_gnt, wr_done, init_busy,
        output mem_In, mem_Address, mem_WE, mem_en, err
    );
endinterface

// File: rtl/weight_access_arbiter.sv
// Weight-memory sequencer: init sweep, then read/write burst arbitration held for OP_LAT cycles.
// Optional macro WR_PRIORITY_EN: ties in IDLE always go to the write requester.
module weight_access_arbiter #(
    parameter int DEPTH  = 65,
    parameter int N      = 10,
    parameter int AW     = 7,
    parameter int OP_LAT = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    weight_access_arbiter_if.slave io_bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(OP_LAT + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(DEPTH - 1);
    localparam logic [OW-1:0] OP_LAST   = OW'(OP_LAT - 1);
    localparam logic [AW:0]   N_EXT     = (AW+1)'(N);
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic          SIDE_RD   = 1'b0;
    localparam logic          SIDE_WR   = 1'b1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_init_cnt;
    logic [IW-1:0] w_init_cnt_nxt;
    logic [OW-1:0] r_op_cnt;
    logic [OW-1:0] w_op_cnt_nxt;
    logic          r_side;
    logic          w_side_nxt;

    logic          w_req_any;
    logic          w_grant_side;
    logic [AW-1:0] w_grant_addr;
    logic          w_grant_bad;
    logic          w_take;

    logic          r_rd_gnt,    w_rd_gnt_nxt;
    logic          r_rd_done,   w_rd_done_nxt;
    logic          r_wr_gnt,    w_wr_gnt_nxt;
    logic          r_wr_done,   w_wr_done_nxt;
    logic          r_init_busy, w_init_busy_nxt;
    logic          r_mem_in,    w_mem_in_nxt;
    logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic          r_mem_we,    w_mem_we_nxt;
    logic          r_mem_en,    w_mem_en_nxt;
    logic          r_err,       w_err_nxt;

`ifndef WR_PRIORITY_EN
    logic          r_last_grant;

    // Round-robin history: remembers which side owned the memory last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= SIDE_WR;
        end else if (w_take) begin
            r_last_grant <= w_grant_side;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end
`endif

    // Request selection and address range check for the candidate grant.
    always_comb begin
        w_req_any    = io_bus.rd_req | io_bus.wr_req;
        w_grant_side = SIDE_RD;
        if (io_bus.rd_req && io_bus.wr_req) begin
`ifdef WR_PRIORITY_EN
            w_grant_side = SIDE_WR;
`else
            w_grant_side = ~r_last_grant;
`endif
        end else if (io_bus.wr_req) begin
            w_grant_side = SIDE_WR;
        end else begin
            w_grant_side = SIDE_RD;
        end
        w_grant_addr = (w_grant_side == SIDE_WR) ? io_bus.wr_addr : io_bus.rd_addr;
        w_grant_bad  = (({1'b0, w_grant_addr} + N_EXT) > DEPTH_EXT);
        w_take       = (r_state == ST_IDLE) && !io_bus.init_start && w_req_any;
    end

    // State and sequencing counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= {IW{1'b0}};
            r_op_cnt   <= {OW{1'b0}};
            r_side     <= SIDE_RD;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_op_cnt   <= w_op_cnt_nxt;
            r_side     <= w_side_nxt;
        end
    end

    // Next-state logic; INIT leaves only after the busy flag has been up for DEPTH cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_init_busy && (r_init_cnt == INIT_LAST)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (io_bus.init_start) begin
                    w_state_nxt = ST_INIT;
                end else if (w_req_any) begin
                    w_state_nxt = w_grant_bad ? ST_RESP : ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_op_cnt == OP_LAST) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Output logic: next values of every registered output, derived from the next state.
    always_comb begin
        w_side_nxt      = w_take ? w_grant_side : r_side;
        w_init_cnt_nxt  = {IW{1'b0}};
        w_op_cnt_nxt    = {OW{1'b0}};
        if ((r_state == ST_INIT) && r_init_busy && (w_state_nxt == ST_INIT)) begin
            w_init_cnt_nxt = r_init_cnt + {{(IW-1){1'b0}}, 1'b1};
        end else begin
            w_init_cnt_nxt = {IW{1'b0}};
        end
        if ((r_state == ST_ACCESS) && (w_state_nxt == ST_ACCESS)) begin
            w_op_cnt_nxt = r_op_cnt + {{(OW-1){1'b0}}, 1'b1};
        end else begin
            w_op_cnt_nxt = {OW{1'b0}};
        end
        w_init_busy_nxt = (w_state_nxt == ST_INIT);
        w_mem_in_nxt    = (w_state_nxt == ST_INIT);
        w_mem_en_nxt    = (w_state_nxt == ST_ACCESS);
        w_rd_gnt_nxt    = ((w_state_nxt == ST_ACCESS) || (w_state_nxt == ST_RESP)) &&
                          (w_side_nxt == SIDE_RD);
        w_wr_gnt_nxt    = ((w_state_nxt == ST_ACCESS) || (w_state_nxt == ST_RESP)) &&
                          (w_side_nxt == SIDE_WR);
        w_rd_done_nxt   = (w_state_nxt == ST_RESP) && (w_side_nxt == SIDE_RD);
        w_wr_done_nxt   = (w_state_nxt == ST_RESP) && (w_side_nxt == SIDE_WR);
        // Address and direction only move on a real memory access, so they stay stable throughout.
        if (w_take && !w_grant_bad) begin
            w_mem_addr_nxt = w_grant_addr;
            w_mem_we_nxt   = w_grant_side;
        end else begin
            w_mem_addr_nxt = r_mem_addr;
            w_mem_we_nxt   = r_mem_we;
        end
        w_err_nxt = r_err | (w_take & w_grant_bad);
    end

    // Output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_gnt    <= 1'b0;
            r_rd_done   <= 1'b0;
            r_wr_gnt    <= 1'b0;
            r_wr_done   <= 1'b0;
            r_init_busy <= 1'b0;
            r_mem_in    <= 1'b0;
            r_mem_addr  <= {AW{1'b0}};
            r_mem_we    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rd_gnt    <= w_rd_gnt_nxt;
            r_rd_done   <= w_rd_done_nxt;
            r_wr_gnt    <= w_wr_gnt_nxt;
            r_wr_done   <= w_wr_done_nxt;
            r_init_busy <= w_init_busy_nxt;
            r_mem_in    <= w_mem_in_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign io_bus.rd_gnt      = r_rd_gnt;
    assign io_bus.rd_done     = r_rd_done;
    assign io_bus.wr_gnt      = r_wr_gnt;
    assign io_bus.wr_done     = r_wr_done;
    assign io_bus.init_busy   = r_init_busy;
    assign io_bus.mem_In      = r_mem_in;
    assign io_bus.mem_Address = r_mem_addr;
    assign io_bus.mem_WE      = r_mem_we;
    assign io_bus.mem_en      = r_mem_en;
    assign io_bus.err         = r_err;
endmodule

// File: tb/tb_weight_access_arbiter.sv
// Directed table-driven bench for weight_access_arbiter (DEPTH=65, N=10, OP_LAT=2).
module tb_weight_access_arbiter;
    localparam int DEPTH  = 65;
    localparam int OP_LAT = 2;
`ifdef WR_PRIORITY_EN
    localparam logic TIE_WR = 1'b1;
`else
    localparam logic TIE_WR = 1'b0;
`endif

    typedef struct {
        logic       rd;
        logic [6:0] rd_addr;
        logic       wr;
        logic [6:0] wr_addr;
        logic       exp_side;
        logic       exp_bad;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    logic exp_err;
    vec_t tbl [9];

    weight_access_arbiter_if #(.AW(7)) bus ();

    weight_access_arbiter #(
        .DEPTH(65), .N(10), .AW(7), .OP_LAT(2)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_gnt"},    32'(bus.rd_gnt),      32'd0);
        chk({tag, " wr_gnt"},    32'(bus.wr_gnt),      32'd0);
        chk({tag, " rd_done"},   32'(bus.rd_done),     32'd0);
        chk({tag, " wr_done"},   32'(bus.wr_done),     32'd0);
        chk({tag, " init_busy"}, 32'(bus.init_busy),   32'd0);
        chk({tag, " mem_In"},    32'(bus.mem_In),      32'd0);
        chk({tag, " mem_Addr"},  32'(bus.mem_Address), 32'd0);
        chk({tag, " mem_WE"},    32'(bus.mem_WE),      32'd0);
        chk({tag, " mem_en"},    32'(bus.mem_en),      32'd0);
        chk({tag, " err"},       32'(bus.err),         32'd0);
    endtask

    // Called on the negedge where init_busy must first be high.
    task automatic check_init(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            chk({tag, " init_busy"}, 32'(bus.init_busy), 32'd1);
            chk({tag, " mem_In"},    32'(bus.mem_In),    32'd1);
            chk({tag, " no_gnt"},    32'({bus.rd_gnt, bus.wr_gnt}), 32'd0);
            chk({tag, " no_done"},   32'({bus.rd_done, bus.wr_done}), 32'd0);
            chk({tag, " mem_en"},    32'(bus.mem_en),    32'd0);
            @(negedge clk);
        end
        chk({tag, " busy_end"},  32'(bus.init_busy), 32'd0);
        chk({tag, " mem_In_end"},32'(bus.mem_In),    32'd0);
        chk({tag, " idle_gnt"},  32'({bus.rd_gnt, bus.wr_gnt}), 32'd0);
        chk({tag, " err"},       32'(bus.err),       32'(exp_err));
        @(negedge clk);
    endtask

    // Called on the negedge where the grant must first be visible; drops requests on done.
    task automatic check_access(input string tag, input logic side,
                                input logic [6:0] addr, input logic bad);
        logic g_own, g_oth, d_own;
        if (!bad) begin
            for (int k = 0; k < OP_LAT; k++) begin
                g_own = side ? bus.wr_gnt : bus.rd_gnt;
                g_oth = side ? bus.rd_gnt : bus.wr_gnt;
                d_own = side ? bus.wr_done : bus.rd_done;
                chk({tag, " gnt"},      32'(g_own),           32'd1);
                chk({tag, " other"},    32'(g_oth),           32'd0);
                chk({tag, " mem_en"},   32'(bus.mem_en),      32'd1);
                chk({tag, " mem_Addr"}, 32'(bus.mem_Address), 32'(addr));
                chk({tag, " mem_WE"},   32'(bus.mem_WE),      32'(side));
                chk({tag, " early"},    32'(d_own),           32'd0);
                chk({tag, " mem_In"},   32'(bus.mem_In),      32'd0);
                @(negedge clk);
            end
        end else begin
            exp_err = 1'b1;
        end
        g_own = side ? bus.wr_gnt : bus.rd_gnt;
        g_oth = side ? bus.rd_gnt : bus.wr_gnt;
        d_own = side ? bus.wr_done : bus.rd_done;
        chk({tag, " resp_done"}, 32'(d_own),      32'd1);
        chk({tag, " resp_gnt"},  32'(g_own),      32'd1);
        chk({tag, " resp_oth"},  32'(g_oth),      32'd0);
        chk({tag, " resp_en"},   32'(bus.mem_en), 32'd0);
        chk({tag, " err"},       32'(bus.err),    32'(exp_err));
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        @(negedge clk);
        chk({tag, " idle_gnt"},  32'({bus.rd_gnt, bus.wr_gnt}),   32'd0);
        chk({tag, " idle_done"}, 32'({bus.rd_done, bus.wr_done}), 32'd0);
        chk({tag, " idle_err"},  32'(bus.err), 32'(exp_err));
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        exp_err = 1'b0;
        tbl[0] = '{1'b1, 7'd20, 1'b0, 7'd0,  1'b0, 1'b0};
        tbl[1] = '{1'b0, 7'd0,  1'b1, 7'd60, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 7'd0,  1'b1, 7'd30, TIE_WR ? 1'b1 : 1'b0, 1'b0};
        tbl[3] = '{1'b1, 7'd0,  1'b1, 7'd30, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 7'd0,  1'b1, 7'd30, TIE_WR ? 1'b1 : 1'b0, 1'b0};
        tbl[5] = '{1'b1, 7'd0,  1'b1, 7'd30, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 7'd0,  1'b1, 7'd55, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 7'd56, 1'b0, 7'd0,  1'b0, 1'b1};
        tbl[8] = '{1'b1, 7'd0,  1'b0, 7'd0,  1'b0, 1'b0};

        rst_n          = 1'b0;
        bus.init_start = 1'b0;
        bus.rd_req     = 1'b1;
        bus.rd_addr    = 7'd5;
        bus.wr_req     = 1'b0;
        bus.wr_addr    = 7'd0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_init("init_rst");
        check_access("post_init_rd", 1'b0, 7'd5, 1'b0);

        for (int v = 0; v < 9; v++) begin
            bus.rd_req  = tbl[v].rd;
            bus.rd_addr = tbl[v].rd_addr;
            bus.wr_req  = tbl[v].wr;
            bus.wr_addr = tbl[v].wr_addr;
            @(negedge clk);
            check_access($sformatf("vec%0d", v), tbl[v].exp_side,
                         tbl[v].exp_side ? tbl[v].wr_addr : tbl[v].rd_addr, tbl[v].exp_bad);
        end

        // init_start beats a pending read
        bus.init_start = 1'b1;
        bus.rd_req     = 1'b1;
        bus.rd_addr    = 7'd40;
        @(negedge clk);
        bus.init_start = 1'b0;
        check_init("init_req");
        check_access("after_init_rd", 1'b0, 7'd40, 1'b0);

        // reset in the middle of an access
        bus.rd_req  = 1'b1;
        bus.rd_addr = 7'd10;
        @(negedge clk);
        chk("abort_pre_gnt", 32'(bus.rd_gnt), 32'd1);
        #2;
        rst_n      = 1'b0;
        bus.rd_req = 1'b0;
        exp_err    = 1'b0;
        #1;
        chk_all_zero("abort_async");
        @(negedge clk);
        chk_all_zero("abort_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_init("init_abort");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/weight_access_arbiter.md
Name: weight_access_arbiter

Overview:
- Sequences the shared 10-bit weight memory (65 words, N-word burst access): random initialisation sweep after reset or on request, then arbitration between a read requester (forward-pass unit) and a write requester (weight-update unit).
- Sits between those two requesters and the weight memory's In/Address/WE pins.
- Holds each granted burst stable for the memory's divided-clock access time.

Parameters:
- DEPTH, 65, number of weight words in memory
- N, 10, words per burst access
- AW, 7, address width
- OP_LAT, 2, Clock cycles a burst must be held (memory runs on divided clock)

Ports:
- Clock  input  1  system clock, rising edge
- Rst  input  1  asynchronous active-low reset
- init_start  input  1  request random re-initialisation; sampled in IDLE only
- rd_req  input  1  read burst request; held until rd_done
- rd_addr  input  AW  read burst base address
- wr_req  input  1  write burst request; held until wr_done
- wr_addr  input  AW  write burst base address
- rd_gnt  output  1  read burst owns memory
- rd_done  output  1  one-cycle pulse: read burst complete
- wr_gnt  output  1  write burst owns memory
- wr_done  output  1  one-cycle pulse: write burst complete
- init_busy  output  1  init sweep in progress
- mem_In  output  1  memory randomise enable
- mem_Address  output  AW  burst base address to memory
- mem_WE  output  1  1 = write burst, 0 = read burst
- mem_en  output  1  burst strobe, high for the whole access
- err  output  1  sticky: out-of-range request seen

Behaviour:
- Reset (Rst=0, async): all outputs 0, last_grant=WR, counters 0, state=INIT on release.
- States: INIT, IDLE, ACCESS, RESP.
- INIT:
  - mem_In=1 and init_busy=1 for exactly DEPTH cycles; init_cnt counts 0..DEPTH-1; then IDLE.
  - rd_req/wr_req ignored; no gnt asserted.
- IDLE:
  - init_start=1 → INIT; takes precedence over any pending req.
  - Else one req → grant it.
  - Both req → round-robin: grant the side not equal to last_grant, then update last_grant.
  - First tie after reset → RD.
- Range check at grant:
  - addr+N > DEPTH (computed AW+1 bits wide) → no memory access; go to RESP, pulse that side's done, set err.
  - err clears only on reset.
- ACCESS:
  - Latch addr and type on entry; mem_Address and mem_WE are stable for the whole access.
  - mem_en=1 for exactly OP_LAT cycles; gnt=1.
  - Requester dropping req mid-access does not abort; the access completes.
- RESP:
  - One cycle: done=1, gnt still 1, mem_en=0; then IDLE.
  - Grant→done latency = OP_LAT+1 cycles.
  - A req still high in the cycle after done is treated as a new request.
- Never both gnt high; mem_In and mem_en are never high together.
- Reset mid-ACCESS aborts without a done pulse, then INIT reruns.

Optional Feature:
- WR_PRIORITY_EN defined: ties in IDLE always grant WR; last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- Release Rst → init_busy=1 and mem_In=1 for 65 cycles, then 0; no gnt during that time, even with rd_req=1.
- IDLE, rd_req=1, rd_addr=20 → rd_gnt next cycle; mem_en=1, mem_Address=20, mem_WE=0 for 2 cycles; rd_done pulse on cycle 3.
- rd_req and wr_req held high, addrs 0 and 30 → grants alternate RD, WR, RD, WR; with WR_PRIORITY_EN → WR every time.
- wr_req=1, wr_addr=60 (60+10>65) → mem_en stays 0; wr_done pulses; err=1 and remains 1.
- init_start=1 together with rd_req=1 in IDLE → INIT runs 65 cycles first, then rd_gnt.
- Rst pulled low during ACCESS → outputs 0 immediately; no done pulse; 65-cycle INIT after release.
